// File: rtl/cpu_error_ctrl_pkg.sv
// cpu_error_ctrl_pkg: shared definitions for the CPU error-handling controller.
//   - source index constants (ERR_SRC_ICACHE .. ERR_SRC_WB)
//   - controller state type (ERR_ST_IDLE, ERR_ST_HALT_REQ, ERR_ST_HALTED, ERR_ST_TIMEOUT)
//   - NUM_SRC / ID_W defaults and the reset-active level
// Optional feature macro used by the other files: ERR_MASK_EN.
package cpu_error_ctrl_pkg;

  localparam int unsigned ERR_SRC_ICACHE = 0;
  localparam int unsigned ERR_SRC_DCACHE = 1;
  localparam int unsigned ERR_SRC_IF     = 2;
  localparam int unsigned ERR_SRC_ID     = 3;
  localparam int unsigned ERR_SRC_LAUNCH = 4;
  localparam int unsigned ERR_SRC_EX     = 5;
  localparam int unsigned ERR_SRC_MM     = 6;
  localparam int unsigned ERR_SRC_MEM    = 7;
  localparam int unsigned ERR_SRC_WB     = 8;

  localparam int NUM_SRC_DEF = 9;
  localparam int ID_W_DEF    = 4;

  // Reset is active-low.
  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    ERR_ST_IDLE     = 2'd0,
    ERR_ST_HALT_REQ = 2'd1,
    ERR_ST_HALTED   = 2'd2,
    ERR_ST_TIMEOUT  = 2'd3
  } err_state_e;

endpackage

// File: rtl/cpu_error_ctrl_if.sv
// cpu_error_ctrl_if: error/halt signal bundle between the pipeline and the
// error controller.
//   slave  modport: controller side (error strobes, ack, clear in; record out)
//   master modport: pipeline/debug side (the reverse)
// With ERR_MASK_EN defined, err_mask_i (NUM_SRC bits) is added as a
// controller input.
interface cpu_error_ctrl_if #(
  parameter int NUM_SRC = 9,
  parameter int ID_W    = 4,
  parameter int CYC_W   = 32
);
  logic [NUM_SRC-1:0] err_src_i;
  logic               halt_ack_i;
  logic               clear_i;
`ifdef ERR_MASK_EN
  logic [NUM_SRC-1:0] err_mask_i;
`endif
  logic               halt_req_o;
  logic               err_valid_o;
  logic [ID_W-1:0]    err_id_o;
  logic [CYC_W-1:0]   err_cycle_o;
  logic               err_multi_o;
  logic               halt_timeout_o;
  logic               cpu_inner_error_o;

`ifdef ERR_MASK_EN
  modport slave (
    input  err_src_i, halt_ack_i, clear_i, err_mask_i,
    output halt_req_o, err_valid_o, err_id_o, err_cycle_o, err_multi_o,
           halt_timeout_o, cpu_inner_error_o
  );
  modport master (
    output err_src_i, halt_ack_i, clear_i, err_mask_i,
    input  halt_req_o, err_valid_o, err_id_o, err_cycle_o, err_multi_o,
           halt_timeout_o, cpu_inner_error_o
  );
`else
  modport slave (
    input  err_src_i, halt_ack_i, clear_i,
    output halt_req_o, err_valid_o, err_id_o, err_cycle_o, err_multi_o,
           halt_timeout_o, cpu_inner_error_o
  );
  modport master (
    output err_src_i, halt_ack_i, clear_i,
    input  halt_req_o, err_valid_o, err_id_o, err_cycle_o, err_multi_o,
           halt_timeout_o, cpu_inner_error_o
  );
`endif

endinterface

// File: rtl/cpu_error_ctrl_prio_enc.sv
// cpu_err_prio_enc: combinational highest-index-wins priority encoder.
//   req_i   : NUM_SRC request bits
//   valid_o : any request set
//   id_o    : index of the highest set bit (0 when none)
module cpu_err_prio_enc #(
  parameter int NUM_SRC = 9,
  parameter int ID_W    = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Ascending scan: the last set bit seen is the highest, i.e. the oldest stage.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/cpu_error_ctrl.sv
// cpu_error_ctrl: error-handling controller for the 7-stage pipeline.
// Captures the highest-priority error source and the cycle it was seen on,
// requests a pipeline halt, waits for the ack (or times out) and holds a
// sticky error record until clear_i.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : cpu_error_ctrl_if.slave (err_src_i, halt_ack_i, clear_i,
//                halt_req_o, err_valid_o, err_id_o, err_cycle_o,
//                err_multi_o, halt_timeout_o, cpu_inner_error_o)
// Optional: define ERR_MASK_EN to add err_mask_i; masked sources are ignored.
module cpu_error_ctrl
  import cpu_error_ctrl_pkg::*;
#(
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int ID_W         = ID_W_DEF,
  parameter int CYC_W        = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  cpu_error_ctrl_if.slave  bus
);

  localparam int TMO_W = (HALT_TIMEOUT < 256) ? 8 : $clog2(HALT_TIMEOUT + 1);

  err_state_e         state_q;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [TMO_W-1:0]   tmo_q;
  logic               halt_req_q;
  logic               err_valid_q;
  logic [ID_W-1:0]    err_id_q;
  logic [CYC_W-1:0]   err_cycle_q;
  logic               err_multi_q;
  logic               halt_timeout_q;

  logic [NUM_SRC-1:0] src_eff;
  logic               any_src;
  logic [ID_W-1:0]    win_id;

  always_comb begin
`ifdef ERR_MASK_EN
    src_eff = bus.err_src_i & ~bus.err_mask_i;
`else
    src_eff = bus.err_src_i;
`endif
    cyc_d = cyc_q + CYC_W'(1);
  end

  cpu_err_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req_i   (src_eff),
    .valid_o (any_src),
    .id_o    (win_id)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      state_q        <= ERR_ST_IDLE;
      cyc_q          <= '0;
      tmo_q          <= '0;
      halt_req_q     <= 1'b0;
      err_valid_q    <= 1'b0;
      err_id_q       <= '0;
      err_cycle_q    <= '0;
      err_multi_q    <= 1'b0;
      halt_timeout_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      if (state_q == ERR_ST_IDLE) begin
        // clear_i is ignored here; a pending source is captured.
        if (any_src) begin
          state_q     <= ERR_ST_HALT_REQ;
          err_valid_q <= 1'b1;
          halt_req_q  <= 1'b1;
          err_id_q    <= win_id;
          err_cycle_q <= cyc_q;
          tmo_q       <= '0;
        end
      end else if (bus.clear_i) begin
        // Clear beats any source on the same cycle; a held source is
        // picked up from IDLE on the next cycle.
        state_q        <= ERR_ST_IDLE;
        halt_req_q     <= 1'b0;
        err_valid_q    <= 1'b0;
        err_id_q       <= '0;
        err_cycle_q    <= '0;
        err_multi_q    <= 1'b0;
        halt_timeout_q <= 1'b0;
      end else begin
        if (any_src) err_multi_q <= 1'b1;
        unique case (state_q)
          ERR_ST_HALT_REQ: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (bus.halt_ack_i) begin
              state_q <= ERR_ST_HALTED;
            end else if (tmo_q == TMO_W'(HALT_TIMEOUT)) begin
              state_q        <= ERR_ST_TIMEOUT;
              halt_timeout_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          ERR_ST_HALTED, ERR_ST_TIMEOUT: ;
          default: state_q <= ERR_ST_IDLE;
        endcase
      end
    end
  end

  assign bus.halt_req_o        = halt_req_q;
  assign bus.err_valid_o       = err_valid_q;
  assign bus.err_id_o          = err_id_q;
  assign bus.err_cycle_o       = err_cycle_q;
  assign bus.err_multi_o       = err_multi_q;
  assign bus.halt_timeout_o    = halt_timeout_q;
  assign bus.cpu_inner_error_o = err_valid_q;

endmodule

// File: tb/tb_cpu_error_ctrl.sv
// tb_cpu_error_ctrl: directed + randomized bench for cpu_error_ctrl.
// Outputs are compared every cycle against a behavioural record model;
// the ERR_MASK_EN section is exercised only when the macro is defined.
module tb_cpu_error_ctrl;
  localparam int NS = 9;
  localparam int IW = 4;
  localparam int CW = 32;
  localparam int HT = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_error_ctrl_if #(.NUM_SRC(NS), .ID_W(IW), .CYC_W(CW)) bus ();

  cpu_error_ctrl #(
    .NUM_SRC      (NS),
    .ID_W         (IW),
    .CYC_W        (CW),
    .HALT_TIMEOUT (HT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an error record plus how far the halt handshake got.
  logic [NS-1:0] mask_v;
  longint        mcyc;
  logic          m_valid, m_multi, m_acked, m_tout;
  int            m_id;
  longint        m_cycle;
  int            m_since;

  function automatic int top_idx(input logic [NS-1:0] v);
    for (int i = NS - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("halt_req", 64'(bus.halt_req_o), 64'(m_valid));
    chk("err_valid", 64'(bus.err_valid_o), 64'(m_valid));
    chk("err_id", 64'(bus.err_id_o), 64'(m_id));
    chk("err_cycle", 64'(bus.err_cycle_o), 64'(m_cycle));
    chk("err_multi", 64'(bus.err_multi_o), 64'(m_multi));
    chk("halt_timeout", 64'(bus.halt_timeout_o), 64'(m_tout));
    chk("cpu_inner_error", 64'(bus.cpu_inner_error_o), 64'(m_valid));
  endtask

  task automatic model_reset();
    mcyc = 0; m_valid = 0; m_multi = 0; m_acked = 0; m_tout = 0;
    m_id = 0; m_cycle = 0; m_since = 0;
  endtask

  task automatic model_edge(input logic [NS-1:0] src, input logic ack, input logic clr);
    logic [NS-1:0] eff;
    longint now;
    eff = src & ~mask_v;
    now = mcyc;
    mcyc = (mcyc + 1) % (64'd1 << CW);
    if (!m_valid) begin
      if (eff != '0) begin
        m_valid = 1; m_id = top_idx(eff); m_cycle = now;
        m_since = 0; m_acked = 0; m_tout = 0; m_multi = 0;
      end
    end else if (clr) begin
      m_valid = 0; m_multi = 0; m_acked = 0; m_tout = 0; m_id = 0; m_cycle = 0;
    end else begin
      if (eff != '0) m_multi = 1;
      if (!m_acked && !m_tout) begin
        if (ack) m_acked = 1;
        else if (m_since == HT) m_tout = 1;
        else m_since++;
      end
    end
  endtask

  task automatic step(input logic [NS-1:0] src, input logic ack, input logic clr);
    bus.err_src_i  = src;
    bus.halt_ack_i = ack;
    bus.clear_i    = clr;
`ifdef ERR_MASK_EN
    bus.err_mask_i = mask_v;
`endif
    @(posedge clk);
    model_edge(src, ack, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.err_src_i = '0; bus.halt_ack_i = 1'b0; bus.clear_i = 1'b0;
`ifdef ERR_MASK_EN
    bus.err_mask_i = mask_v;
`endif
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NS-1:0] s;
    mask_v = '0;
    model_reset();

    // Reset state.
    do_reset();

    // Single ex error at cycle 10, ack three cycles later.
    while (mcyc != 10) step('0, 1'b0, 1'b0);
    step(NS'(1) << 5, 1'b0, 1'b0);
    chk("ex_valid", 64'(bus.err_valid_o), 64'd1);
    chk("ex_id", 64'(bus.err_id_o), 64'd5);
    chk("ex_cycle", 64'(bus.err_cycle_o), 64'd10);
    chk("ex_req", 64'(bus.halt_req_o), 64'd1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    // Halted: no timeout even well beyond the limit, ack is ignored now.
    for (int i = 0; i < 300; i++) step('0, 1'(i % 7 == 0), 1'b0);
    chk("halted_no_tmo", 64'(bus.halt_timeout_o), 64'd0);
    chk("halted_req", 64'(bus.halt_req_o), 64'd1);
    step('0, 1'b0, 1'b1);
    chk("clr_valid", 64'(bus.err_valid_o), 64'd0);
    step('0, 1'b0, 1'b1);  // clear in IDLE: nothing happens

    // Simultaneous sources 1, 3, 8.
    step(NS'(9'b1_0000_1010), 1'b0, 1'b0);
    chk("simul_id", 64'(bus.err_id_o), 64'd8);
    chk("simul_multi", 64'(bus.err_multi_o), 64'd0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);

    // Late error after capture of id 2.
    step(NS'(1) << 2, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(NS'(1) << 7, 1'b0, 1'b0);
    chk("late_multi", 64'(bus.err_multi_o), 64'd1);
    chk("late_id", 64'(bus.err_id_o), 64'd2);
    step('0, 1'b0, 1'b1);

    // Timeout with no ack.
    s = NS'($urandom_range(1, (1 << NS) - 1));
    step(s, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) step('0, 1'b0, 1'b0);
    chk("pre_tmo", 64'(bus.halt_timeout_o), 64'd0);
    step('0, 1'b0, 1'b0);
    chk("tmo_flag", 64'(bus.halt_timeout_o), 64'd1);
    chk("tmo_req", 64'(bus.halt_req_o), 64'd1);
    step('0, 1'b1, 1'b0);  // late ack does not leave TIMEOUT
    step('0, 1'b0, 1'b1);
    chk("tmo_clr_all", {bus.halt_req_o, bus.err_valid_o, bus.err_multi_o,
                        bus.halt_timeout_o, bus.cpu_inner_error_o}, 64'd0);

    // Ack arriving on the very cycle the timeout would fire.
    step(NS'(1) << 6, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("ack_wins", 64'(bus.halt_timeout_o), 64'd0);
    step('0, 1'b0, 1'b1);

    // Clear together with a held source 0.
    step(NS'(1) << 3, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    step(NS'(1), 1'b0, 1'b1);
    chk("clr_wins", 64'(bus.err_valid_o), 64'd0);
    step(NS'(1), 1'b0, 1'b0);
    chk("recap_valid", 64'(bus.err_valid_o), 64'd1);
    chk("recap_id", 64'(bus.err_id_o), 64'd0);
    step('0, 1'b0, 1'b1);

`ifdef ERR_MASK_EN
    mask_v = NS'(1) << 8;
    step(NS'(9'b1_0001_0000), 1'b0, 1'b0);
    chk("mask_id", 64'(bus.err_id_o), 64'd4);
    step(NS'(1) << 8, 1'b0, 1'b0);
    chk("mask_no_multi", 64'(bus.err_multi_o), 64'd0);
    step('0, 1'b0, 1'b1);
    step(NS'(1) << 8, 1'b0, 1'b0);
    chk("mask_only", 64'(bus.err_valid_o), 64'd0);
`endif

    // Randomized soak.
    for (int i = 0; i < 3000; i++) begin
`ifdef ERR_MASK_EN
      if (i % 500 == 0) mask_v = NS'($urandom);
`endif
      s = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
      step(s, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 30) == 0));
    end

    // Mid-run reset returns everything to zero.
    step(NS'(1) << 1, 1'b0, 1'b0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
